// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern scanner: holds pattern/length/overlap config, scans one frame of
// frame_len valid bits and emits a registered match pulse plus a saturating match count.
module pattern_scan_ctrl #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNTW   = 8,
    parameter int unsigned FRAMEW = 8
) (
    input  logic                         clk,
    input  logic                         R,
    input  logic                         cfg_we,
    input  logic [MAXLEN-1:0]            cfg_pattern,
    input  logic [$clog2(MAXLEN+1)-1:0]  cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         start,
    input  logic [FRAMEW-1:0]            frame_len,
    input  logic                         in_valid,
    input  logic                         in,
    output logic                         busy,
    output logic                         match,
    output logic [CNTW-1:0]              match_count,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int unsigned LW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e              state_q, state_d;
    logic [MAXLEN-1:0]   pat_q, pat_d;
    logic [LW-1:0]       len_q, len_d;
    logic                ovl_q, ovl_d;
    logic                err_q, err_d;
    logic [MAXLEN-2:0]   hist_q, hist_d;
    logic [LW-1:0]       fill_q, fill_d;
    logic [FRAMEW-1:0]   bitcnt_q, bitcnt_d;
    logic [FRAMEW-1:0]   flen_q, flen_d;
    logic                match_q, match_d;
    logic [CNTW-1:0]     count_q, count_d;

    logic [MAXLEN-1:0]   new_hist;
    logic [MAXLEN-1:0]   mask;
    logic [LW-1:0]       new_fill;
    logic [FRAMEW-1:0]   bitcnt_inc;
    logic                hit;
    logic                len_ok;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q  <= StIdle;
            pat_q    <= MAXLEN'(3'b101);
            len_q    <= LW'(3);
            ovl_q    <= 1'b0;
            err_q    <= 1'b0;
            hist_q   <= '0;
            fill_q   <= '0;
            bitcnt_q <= '0;
            flen_q   <= '0;
            match_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            err_q    <= err_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            bitcnt_q <= bitcnt_d;
            flen_q   <= flen_d;
            match_q  <= match_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        err_d    = err_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        bitcnt_d = bitcnt_q;
        flen_d   = flen_q;
        match_d  = 1'b0;
        count_d  = count_q;

        // Match is judged on the history including the bit being accepted this cycle.
        new_hist   = {hist_q, in};
        new_fill   = (fill_q == LW'(MAXLEN)) ? fill_q : fill_q + 1'b1;
        mask       = ~({MAXLEN{1'b1}} << len_q);
        hit        = (new_fill >= len_q) && ((new_hist & mask) == (pat_q & mask));
        bitcnt_inc = bitcnt_q + 1'b1;
        len_ok     = (cfg_len != '0) && (cfg_len <= LW'(MAXLEN));

        if (cfg_we) begin
            if (state_q == StIdle && len_ok) begin
                pat_d = cfg_pattern;
                len_d = cfg_len;
                ovl_d = cfg_overlap;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    flen_d   = frame_len;
                    count_d  = '0;
                    hist_d   = '0;
                    fill_d   = '0;
                    bitcnt_d = '0;
                    state_d  = (frame_len == '0) ? StDone : StScan;
                end
            end
            StScan: begin
                if (in_valid) begin
                    hist_d   = new_hist[MAXLEN-2:0];
                    fill_d   = new_fill;
                    bitcnt_d = bitcnt_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                        // Non-overlapping mode needs a full fresh pattern after each hit.
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                    end
                    if (bitcnt_inc == flen_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign match       = match_q;
    assign match_count = count_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl; a second instance with CNTW=2 shadows the main one to
// exercise count saturation.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       R;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       start;
    logic [7:0] frame_len;
    logic       in_valid;
    logic       in_b;

    logic       busy, match, done, cfg_err;
    logic [7:0] match_count;
    logic       busy2, match2, done2, cfg_err2;
    logic [1:0] match_count2;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.MAXLEN(8), .CNTW(8), .FRAMEW(8)) dut (
        .clk(clk), .R(R), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .start(start), .frame_len(frame_len), .in_valid(in_valid),
        .in(in_b), .busy(busy), .match(match), .match_count(match_count), .done(done),
        .cfg_err(cfg_err)
    );

    pattern_scan_ctrl #(.MAXLEN(8), .CNTW(2), .FRAMEW(8)) dut2 (
        .clk(clk), .R(R), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .start(start), .frame_len(frame_len), .in_valid(in_valid),
        .in(in_b), .busy(busy2), .match(match2), .match_count(match_count2), .done(done2),
        .cfg_err(cfg_err2)
    );

    typedef struct packed {
        logic       m;
        logic       d;
        logic [7:0] c;
        logic       b;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".match"}, {7'd0, match}, 8'd0);
        chk({tag, ".done"}, {7'd0, done}, 8'd0);
        chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
        chk({tag, ".count"}, match_count, 8'd0);
        chk({tag, ".err"}, {7'd0, cfg_err}, 8'd0);
        chk({tag, ".count2"}, {6'd0, match_count2}, 8'd0);
    endtask

    // Drive one cycle, queue what the outputs must show after the edge, then check it.
    task automatic step(input logic s, input logic v, input logic b, input logic em,
                        input logic ed, input int ec, input logic eb, input logic ee,
                        input string tag);
        exp_t e;
        start    = s;
        in_valid = v;
        in_b     = b;
        sb.push_back('{m: em, d: ed, c: 8'(ec), b: eb, e: ee});
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_b     = 1'b0;
        cfg_we   = 1'b0;
        e = sb.pop_front();
        chk({tag, ".match"}, {7'd0, match}, {7'd0, e.m});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, e.d});
        chk({tag, ".count"}, match_count, e.c);
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e.b});
        chk({tag, ".err"}, {7'd0, cfg_err}, {7'd0, e.e});
        chk({tag, ".match2"}, {7'd0, match2}, {7'd0, e.m});
        chk({tag, ".count2"}, {6'd0, match_count2}, (e.c > 8'd3) ? 8'd3 : e.c);
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                       input int ec, input logic ee, input string tag);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ec, 1'b0, ee, tag);
    endtask

    task automatic apply_reset(input string tag);
        R = 1'b0;
        #2;
        chk_zero(tag);
        @(posedge clk);
        #1;
        R = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        R = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        start = 1'b0; frame_len = '0; in_valid = 1'b0; in_b = 1'b0;
        #3;
        chk_zero("reset");
        #10;
        R = 1'b1;
        @(posedge clk);
        #1;

        // Default 101, non-overlap
        frame_len = 8'd5;
        step(1, 0, 0, 0, 0, 0, 1, 0, "t1.start");
        step(0, 1, 1, 0, 0, 0, 1, 0, "t1.b1");
        step(0, 1, 0, 0, 0, 0, 1, 0, "t1.b2");
        step(0, 1, 1, 1, 0, 1, 1, 0, "t1.b3");
        step(0, 1, 0, 0, 0, 1, 1, 0, "t1.b4");
        step(0, 1, 1, 0, 1, 1, 1, 0, "t1.b5");
        step(0, 0, 0, 0, 0, 1, 0, 0, "t1.idle");

        // Overlap on
        cfg(8'h05, 4'd3, 1'b1, 1, 1'b0, "t2.cfg");
        step(1, 0, 0, 0, 0, 0, 1, 0, "t2.start");
        step(0, 1, 1, 0, 0, 0, 1, 0, "t2.b1");
        step(0, 1, 0, 0, 0, 0, 1, 0, "t2.b2");
        step(0, 1, 1, 1, 0, 1, 1, 0, "t2.b3");
        step(0, 1, 0, 0, 0, 1, 1, 0, "t2.b4");
        step(0, 1, 1, 1, 1, 2, 1, 0, "t2.b5");
        step(0, 0, 0, 0, 0, 2, 0, 0, "t2.idle");

        // len 4 pattern 1101, non-overlap, with an in_valid gap
        cfg(8'h0D, 4'd4, 1'b0, 2, 1'b0, "t3.cfg");
        frame_len = 8'd8;
        step(1, 0, 0, 0, 0, 0, 1, 0, "t3.start");
        step(0, 1, 1, 0, 0, 0, 1, 0, "t3.b1");
        step(0, 1, 1, 0, 0, 0, 1, 0, "t3.b2");
        step(0, 0, 1, 0, 0, 0, 1, 0, "t3.gap1");
        step(0, 0, 0, 0, 0, 0, 1, 0, "t3.gap2");
        step(0, 1, 0, 0, 0, 0, 1, 0, "t3.b3");
        step(0, 1, 1, 1, 0, 1, 1, 0, "t3.b4");
        step(0, 1, 1, 0, 0, 1, 1, 0, "t3.b5");
        step(0, 1, 0, 0, 0, 1, 1, 0, "t3.b6");
        step(0, 1, 1, 0, 0, 1, 1, 0, "t3.b7");
        step(0, 1, 0, 0, 1, 1, 1, 0, "t3.b8");
        step(0, 0, 0, 0, 0, 1, 0, 0, "t3.idle");

        // Config errors
        apply_reset("t4.rst");
        cfg(8'h00, 4'd0, 1'b0, 0, 1'b1, "t4.len0");
        cfg(8'hFF, 4'd9, 1'b1, 0, 1'b1, "t4.len9");
        frame_len = 8'd3;
        step(1, 0, 0, 0, 0, 0, 1, 1, "t4a.start");
        step(0, 1, 1, 0, 0, 0, 1, 1, "t4a.b1");
        step(0, 1, 0, 0, 0, 0, 1, 1, "t4a.b2");
        step(0, 1, 1, 1, 1, 1, 1, 1, "t4a.b3");
        step(0, 0, 0, 0, 0, 1, 0, 1, "t4a.idle");
        cfg(8'h05, 4'd3, 1'b0, 1, 1'b0, "t4.clear");
        step(1, 0, 0, 0, 0, 0, 1, 0, "t4b.start");
        step(0, 1, 1, 0, 0, 0, 1, 0, "t4b.b1");
        // A write mid-scan (len 1, pattern 0) would make this 0 bit match if it were taken.
        cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_overlap = 1'b0;
        step(0, 1, 0, 0, 0, 0, 1, 1, "t4b.b2we");
        step(0, 1, 1, 1, 1, 1, 1, 1, "t4b.b3");
        step(0, 0, 0, 0, 0, 1, 0, 1, "t4b.idle");

        // len 1, pattern 1: every 1 matches; shadow instance saturates at 3
        cfg(8'h01, 4'd1, 1'b0, 1, 1'b0, "t5.cfg");
        frame_len = 8'd6;
        step(1, 0, 0, 0, 0, 0, 1, 0, "t5.start");
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 1, 1, (i == 6), i, 1, 0, $sformatf("t5.b%0d", i));
        end
        step(0, 0, 0, 0, 0, 6, 0, 0, "t5.idle");

        // Async reset mid-scan, then zero-length frame
        frame_len = 8'd5;
        step(1, 0, 0, 0, 0, 0, 1, 0, "t6.start");
        step(0, 1, 1, 1, 0, 1, 1, 0, "t6.b1");
        step(0, 1, 1, 1, 0, 2, 1, 0, "t6.b2");
        R = 1'b0;
        #1;
        chk_zero("t6.rst");
        @(posedge clk);
        #1;
        chk_zero("t6.rsthold");
        R = 1'b1;
        step(0, 1, 1, 0, 0, 0, 0, 0, "t6.post1");
        step(0, 1, 1, 0, 0, 0, 0, 0, "t6.post2");
        frame_len = 8'd0;
        step(1, 0, 0, 0, 1, 0, 1, 0, "t6.zero");
        step(0, 0, 0, 0, 0, 0, 0, 0, "t6.zidle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Programmable serial pattern scanner controller. It holds the detector configuration: pattern, length and overlap mode. It sequences one scan over a frame of N valid serial bits, emits a Moore-style registered match pulse and counts matches. A start/done handshake brackets each frame. It sits between a serial input source and the host/control logic that reads match results.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
CNTW, 8, width of match_count
FRAMEW, 8, width of frame_len and internal bit counter

Ports:
clk  input  1  clock, all state updates on posedge
R  input  1  asynchronous reset, active-low (R=0 resets immediately)
cfg_we  input  1  configuration write strobe
cfg_pattern  input  MAXLEN  pattern; bit [cfg_len-1] is the first bit received
cfg_len  input  $clog2(MAXLEN+1)  pattern length in bits
cfg_overlap  input  1  1=overlapping detection, 0=non-overlapping
start  input  1  begin a frame scan (sampled only in IDLE)
frame_len  input  FRAMEW  number of valid bits in the frame, latched on start
in_valid  input  1  serial bit qualifier
in  input  1  serial data bit
busy  output  1  high in SCAN and DONE
match  output  1  registered one-cycle match pulse
match_count  output  CNTW  matches in current/last frame, saturating
done  output  1  one-cycle end-of-frame pulse
cfg_err  output  1  sticky config error flag

Behaviour:
- Reset (R=0, async): state=IDLE; busy=0, match=0, done=0, match_count=0, cfg_err=0. History and fill counter cleared. Config resets to pattern=...0101 (LSBs 3'b101), len=3, overlap=0.
- Reset mid-scan aborts the frame; no done pulse is produced.
- Config write is accepted only in IDLE with 1<=cfg_len<=MAXLEN. The values load at the edge and cfg_err clears.
- cfg_we with cfg_len=0 or >MAXLEN, or cfg_we outside IDLE: config unchanged, cfg_err set. cfg_err holds until the next accepted write.
- FSM has three states: IDLE, SCAN, DONE.
  - IDLE: start=1 -> SCAN. On that edge: latch frame_len, clear match_count, history and bit/fill counters.
  - IDLE: if start=1 and frame_len=0 -> DONE directly.
  - SCAN: each cycle with in_valid=1 accepts one bit. hist <= {hist[MAXLEN-2:0], in}; bitcnt++; fill = min(fill+1, MAXLEN).
  - SCAN -> DONE at the edge accepting bit number frame_len.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- start is ignored outside IDLE. in_valid is ignored outside SCAN.
- Match condition is evaluated on the updated history: fill>=len and hist[len-1:0]==pattern[len-1:0].
- Match timing: match=1 in the cycle after the completing bit is accepted (Moore, one-cycle latency); otherwise 0. match_count increments at the same edge.
- On the frame's final bit, match and done are high in the same cycle.
- Non-overlap: after a match, fill resets to 0, so the next match needs len fresh bits. Overlap: fill is not reset.
- match_count saturates at 2^CNTW-1. match still pulses while the count is saturated.
- match_count holds its value in IDLE until the next start.
- in_valid gaps stall the scan; history is preserved across gaps.
- len=1 is legal: every bit equal to pattern[0] matches.

Test Plan:
1. Default config after reset, start with frame_len=5, bits 1,0,1,0,1 back-to-back -> one match pulse, in the cycle after bit 3; match_count=1; done pulses the cycle after bit 5; busy drops next cycle.
2. Write cfg_overlap=1 (pattern 101, len 3), same stream -> matches after bits 3 and 5; match_count=2; the second match coincides with done.
3. cfg_len=4, pattern 4'b1101, overlap=0, frame_len=8, stream 1,1,0,1,1,0,1,0 with in_valid dropped for 2 cycles between bits 2 and 3 -> match after bit 4 only; gaps add no matches; count=1.
4. cfg_we with cfg_len=0 -> cfg_err=1 and config unchanged (default scan still detects 101). cfg_we during SCAN -> cfg_err=1 and scan unaffected. Valid write in IDLE -> cfg_err=0.
5. CNTW=2, len=1, pattern=1, frame_len=6, six 1s -> six match pulses; match_count goes 1,2,3,3,3,3.
6. R asserted low after bit 2 of a 5-bit frame -> all outputs 0 immediately, no done. start with frame_len=0 -> done pulse the cycle after start; match_count=0.
